// File: rtl/mm_stream_pkg.sv
// Shared types and elaboration helpers for the streaming matrix-multiply engine.
package mm_stream_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CHECK,
    ST_CALC,
    ST_EMIT,
    ST_ILLEGAL
  } mm_state_e;

  // Narrowest accumulator that cannot overflow for a MAX_DIM-term dot product.
  function automatic int mm_out_w_min(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

  // Bits needed to index n distinct values (never less than one bit).
  function automatic int mm_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate stage; MM_SIGNED_EN selects two's-complement arithmetic.
module mm_mac #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  sum
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    prod;
  logic [OUT_W-1:0] prod_ext;
  logic [OUT_W-1:0] acc;

`ifdef MM_SIGNED_EN
  logic signed [PW-1:0] sa;
  logic signed [PW-1:0] sb;
  assign sa       = PW'($signed(a));
  assign sb       = PW'($signed(b));
  assign prod     = sa * sb;
  assign prod_ext = {{(OUT_W-PW){prod[PW-1]}}, prod};
`else
  logic [PW-1:0] ua;
  logic [PW-1:0] ub;
  assign ua       = PW'(a);
  assign ub       = PW'(b);
  assign prod     = ua * ub;
  assign prod_ext = {{(OUT_W-PW){1'b0}}, prod};
`endif

  // sum already includes this cycle's product so the caller can register it directly.
  assign sum = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/mm_stream_param.sv
// Streaming matrix-multiply engine: loads A then B, checks shapes, emits A*B row-major.
// Optional macro MM_SIGNED_EN switches the arithmetic to two's complement.
module mm_stream_param
  import mm_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 4,
  parameter int OUT_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              col_end,
  input  logic              row_end,
  output logic              busy,
  output logic              valid,
  output logic              is_legal,
  output logic [OUT_W-1:0]  out_data,
  output logic              change_row,
  output mm_state_e         dbg_state
);

  localparam int IDX_W  = mm_idx_w(MAX_DIM);
  localparam int DIM_W  = mm_idx_w(MAX_DIM + 2);
  localparam int ELEM_W = mm_idx_w(MAX_DIM * MAX_DIM + 1);
  localparam logic [DIM_W-1:0]  MAX_D = DIM_W'(MAX_DIM);
  localparam logic [ELEM_W-1:0] MAX_E = ELEM_W'(MAX_DIM * MAX_DIM);
  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);

  if (OUT_W < mm_out_w_min(DATA_W, MAX_DIM)) begin : g_out_w_check
    $error("mm_stream_param: OUT_W is too narrow for DATA_W and MAX_DIM");
  end

  mm_state_e state, next_state;

  logic [DATA_W-1:0] buf_a [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] buf_b [MAX_DIM][MAX_DIM];

  logic [DIM_W-1:0]  col_cnt, row_cnt, first_cols;
  logic [ELEM_W-1:0] elem_cnt;
  logic [DIM_W-1:0]  rows_a, cols_a, rows_b, cols_b;
  logic              shape_err;
  logic [IDX_W-1:0]  i_idx, j_idx, k_idx;

  logic              accept, in_range, overflow, width_err, row_done;
  logic [DIM_W-1:0]  col_cnt_p1;
  logic              k_last, j_last, i_last, shape_ok;
  logic              mac_clr, mac_en;
  logic [OUT_W-1:0]  mac_sum;
  logic              valid_d, is_legal_d, change_row_d;
  logic [OUT_W-1:0]  out_data_d;

  // Handshake: an element transfers on a rising edge when in_valid && !busy;
  // busy is the only backpressure and col_end/row_end are ignored otherwise.
  assign busy      = !(state == ST_LOAD_A || state == ST_LOAD_B);
  assign accept    = in_valid && !busy;
  assign dbg_state = state;

  assign row_done   = col_end || row_end;
  assign col_cnt_p1 = col_cnt + ONE_D;
  assign in_range   = (col_cnt < MAX_D) && (row_cnt < MAX_D) && (elem_cnt < MAX_E);
  assign overflow   = (col_cnt == MAX_D) || (row_cnt == MAX_D) || (elem_cnt == MAX_E);
  assign width_err  = row_done && (row_cnt != '0) && (col_cnt_p1 != first_cols);

  assign k_last   = (DIM_W'(k_idx) == cols_a - ONE_D);
  assign j_last   = (DIM_W'(j_idx) == cols_b - ONE_D);
  assign i_last   = (DIM_W'(i_idx) == rows_a - ONE_D);
  assign shape_ok = (cols_a == rows_b) && !shape_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD_A;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD_A:  if (accept && row_end) next_state = ST_LOAD_B;
      ST_LOAD_B:  if (accept && row_end) next_state = ST_CHECK;
      ST_CHECK:   next_state = shape_ok ? ST_CALC : ST_ILLEGAL;
      ST_CALC:    if (k_last) next_state = ST_EMIT;
      ST_EMIT:    next_state = (i_last && j_last) ? ST_LOAD_A : ST_CALC;
      ST_ILLEGAL: next_state = ST_LOAD_A;
      default:    next_state = ST_LOAD_A;
    endcase
  end

  // Result outputs are decoded from next_state so the registered strobe lines up with EMIT/ILLEGAL.
  always_comb begin
    valid_d      = 1'b0;
    is_legal_d   = 1'b0;
    out_data_d   = '0;
    change_row_d = 1'b0;
    case (next_state)
      ST_EMIT: begin
        valid_d      = 1'b1;
        is_legal_d   = 1'b1;
        out_data_d   = mac_sum;
        change_row_d = j_last;
      end
      ST_ILLEGAL: valid_d = 1'b1;
      default: ;
    endcase
    mac_en  = (state == ST_CALC);
    mac_clr = (next_state == ST_CALC) && (state != ST_CALC);
  end

  mm_mac #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr),
    .en (mac_en),
    .a  (buf_a[i_idx][k_idx]),
    .b  (buf_b[k_idx][j_idx]),
    .sum(mac_sum)
  );

  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      if (state == ST_LOAD_A) begin
        buf_a[row_cnt[IDX_W-1:0]][col_cnt[IDX_W-1:0]] <= in_data;
      end else begin
        buf_b[row_cnt[IDX_W-1:0]][col_cnt[IDX_W-1:0]] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      first_cols <= '0;
      elem_cnt   <= '0;
      rows_a     <= '0;
      cols_a     <= '0;
      rows_b     <= '0;
      cols_b     <= '0;
      shape_err  <= 1'b0;
      i_idx      <= '0;
      j_idx      <= '0;
      k_idx      <= '0;
      valid      <= 1'b0;
      is_legal   <= 1'b0;
      out_data   <= '0;
      change_row <= 1'b0;
    end else begin
      if (accept) begin
        if (overflow || width_err) shape_err <= 1'b1;
        elem_cnt <= (elem_cnt == MAX_E) ? elem_cnt : elem_cnt + ELEM_W'(1);
        if (row_end) begin
          // The single-row case has not latched first_cols yet, so use the live count.
          if (state == ST_LOAD_A) begin
            rows_a <= row_cnt + ONE_D;
            cols_a <= (row_cnt == '0) ? col_cnt_p1 : first_cols;
          end else begin
            rows_b <= row_cnt + ONE_D;
            cols_b <= (row_cnt == '0) ? col_cnt_p1 : first_cols;
          end
          col_cnt  <= '0;
          row_cnt  <= '0;
          elem_cnt <= '0;
        end else if (col_end) begin
          if (row_cnt == '0) first_cols <= col_cnt_p1;
          row_cnt <= (row_cnt == MAX_D) ? row_cnt : row_cnt + ONE_D;
          col_cnt <= '0;
        end else begin
          col_cnt <= (col_cnt == MAX_D) ? col_cnt : col_cnt_p1;
        end
      end
      if (state != ST_LOAD_A && next_state == ST_LOAD_A) shape_err <= 1'b0;

      case (state)
        ST_CHECK: begin
          i_idx <= '0;
          j_idx <= '0;
          k_idx <= '0;
        end
        ST_CALC: k_idx <= k_last ? '0 : k_idx + 1'b1;
        ST_EMIT: begin
          if (j_last) begin
            j_idx <= '0;
            i_idx <= i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end
        default: ;
      endcase

      valid      <= valid_d;
      is_legal   <= is_legal_d;
      out_data   <= out_data_d;
      change_row <= change_row_d;
    end
  end

endmodule

// File: tb/tb_mm_stream_param.sv
// Self-checking bench for mm_stream_param: directed test-plan cases plus randomized jobs.
`timescale 1ns/1ps
module tb_mm_stream_param;
  import mm_stream_pkg::*;

  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 4;
  localparam int OUT_W   = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, col_end, row_end;
  logic              busy, valid, is_legal, change_row;
  logic [OUT_W-1:0]  out_data;
  mm_state_e         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  int a_vals[$], a_lens[$], b_vals[$], b_lens[$];

  mm_stream_param #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .col_end(col_end), .row_end(row_end), .busy(busy), .valid(valid),
    .is_legal(is_legal), .out_data(out_data), .change_row(change_row),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint elem_val(input int v);
`ifdef MM_SIGNED_EN
    return (v >= (1 << (DATA_W - 1))) ? longint'(v) - longint'(1 << DATA_W) : longint'(v);
`else
    return longint'(v);
`endif
  endfunction

  task automatic model_product(input int ra, input int ca, input int cb);
    exp_q.delete();
    for (int i = 0; i < ra; i++) begin
      for (int j = 0; j < cb; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < ca; k++) s += elem_val(a_vals[i*ca+k]) * elem_val(b_vals[k*cb+j]);
        exp_q.push_back(s[OUT_W-1:0]);
      end
    end
  endtask

  task automatic set_shape(input int ra, input int ca, input int rb, input int cb);
    a_lens.delete(); a_vals.delete(); b_lens.delete(); b_vals.delete();
    for (int r = 0; r < ra; r++) a_lens.push_back(ca);
    for (int r = 0; r < rb; r++) b_lens.push_back(cb);
    for (int e = 0; e < ra*ca; e++) a_vals.push_back(int'($urandom_range(0, 255)));
    for (int e = 0; e < rb*cb; e++) b_vals.push_back(int'($urandom_range(0, 255)));
  endtask

  // ---------------- driver ----------------
  task automatic drive_matrix(input bit is_b);
    int p;
    int nr;
    p  = 0;
    nr = is_b ? b_lens.size() : a_lens.size();
    for (int r = 0; r < nr; r++) begin
      int len;
      len = is_b ? b_lens[r] : a_lens[r];
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL load_busy: busy=%0b required 0", busy);
        end
        in_valid = 1'b1;
        in_data  = DATA_W'(is_b ? b_vals[p] : a_vals[p]);
        col_end  = (c == len - 1);
        row_end  = (c == len - 1) && (r == nr - 1);
        p++;
      end
    end
  endtask

  // Cycle c counts negedges after edge T (the edge accepting B's row_end).
  task automatic check_job(input string name, input bit legal, input int cols_a,
                           input int cols_b, input bit noise);
    int n;
    int last;
    int idx;
    n    = exp_q.size();
    last = legal ? (cols_a + 2 + (n - 1) * (cols_a + 1)) : 2;
    idx  = 0;
    for (int c = 1; c <= last + 2; c++) begin
      bit ev;
      bit ecr;
      logic [OUT_W-1:0] ed;
      @(negedge clk);
      ev  = legal ? (c >= cols_a + 2 && ((c - cols_a - 2) % (cols_a + 1)) == 0 && c <= last)
                  : (c == 2);
      ed  = '0;
      ecr = 1'b0;
      if (ev && legal) begin
        ed  = exp_q.pop_front();
        ecr = ((idx % cols_b) == cols_b - 1);
        idx++;
      end
      checks++;
      if (valid !== ev || is_legal !== (ev && legal) || out_data !== ed || change_row !== ecr) begin
        errors++;
        $display("FAIL %s_result cycle %0d: valid=%0b is_legal=%0b out_data=%0d change_row=%0b, required %0b %0b %0d %0b",
                 name, c, valid, is_legal, out_data, change_row, ev, ev && legal, ed, ecr);
      end
      checks++;
      if (busy !== (c <= last)) begin
        errors++;
        $display("FAIL %s_busy cycle %0d: busy=%0b required %0b", name, c, busy, c <= last);
      end
      if (noise && c < last) begin
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom_range(0, 255));
        col_end  = 1'($urandom_range(0, 1));
        row_end  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
      end
    end
  endtask

  task automatic run_job(input string name, input bit legal, input int cols_a,
                         input int cols_b, input bit noise);
    drive_matrix(1'b0);
    drive_matrix(1'b1);
    @(posedge clk);
    check_job(name, legal, cols_a, cols_b, noise);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; col_end = 1'b0; row_end = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || is_legal !== 1'b0 || out_data !== '0 ||
        change_row !== 1'b0 || dbg_state !== ST_LOAD_A) begin
      errors++;
      $display("FAIL reset: busy=%0b valid=%0b is_legal=%0b out_data=%0d change_row=%0b state=%0d, required all 0",
               busy, valid, is_legal, out_data, change_row, dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_2x2();
    set_shape(2, 2, 2, 2);
    a_vals = '{1, 2, 3, 4};
    b_vals = '{5, 6, 7, 8};
    exp_q  = '{20'd19, 20'd22, 20'd43, 20'd50};
    run_job("mul_2x2", 1'b1, 2, 2, 1'b0);
  endtask

  task automatic test_illegal_dims();
    set_shape(2, 3, 2, 2);
    exp_q.delete();
    run_job("illegal_2x3_2x2", 1'b0, 3, 2, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_quiet: valid=%0b busy=%0b required 0 0", valid, busy);
      end
    end
  endtask

  task automatic test_1x1_ff();
    set_shape(1, 1, 1, 1);
    a_vals = '{255};
    b_vals = '{255};
`ifdef MM_SIGNED_EN
    exp_q = '{20'd1};
`else
    exp_q = '{20'd65025};
`endif
    run_job("mul_1x1_ff", 1'b1, 1, 1, 1'b0);
  endtask

  task automatic test_4x4_ff();
    set_shape(4, 4, 4, 4);
    exp_q.delete();
    for (int e = 0; e < 16; e++) begin
      a_vals[e] = 255;
      b_vals[e] = 255;
`ifdef MM_SIGNED_EN
      exp_q.push_back(20'd4);
`else
      exp_q.push_back(20'd260100);
`endif
    end
    run_job("mul_4x4_ff", 1'b1, 4, 4, 1'b1);
  endtask

  task automatic test_shape_errors();
    set_shape(2, 3, 3, 1);
    a_lens = '{3, 2};
    exp_q.delete();
    run_job("ragged_rows", 1'b0, 3, 1, 1'b0);
    set_shape(1, 5, 5, 1);
    exp_q.delete();
    run_job("five_cols", 1'b0, 5, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int ra, ca, rb, cb;
      bit legal;
      ra    = int'($urandom_range(1, MAX_DIM));
      ca    = int'($urandom_range(1, MAX_DIM));
      cb    = int'($urandom_range(1, MAX_DIM));
      legal = ($urandom_range(0, 3) != 0);
      rb    = legal ? ca : (ca % MAX_DIM) + 1;
      set_shape(ra, ca, rb, cb);
      if (legal) model_product(ra, ca, cb);
      else exp_q.delete();
      run_job("random", legal, ca, cb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_job();
    int seen;
    int c;
    seen = 0;
    c    = 0;
    set_shape(2, 2, 2, 2);
    a_vals = '{1, 2, 3, 4};
    b_vals = '{5, 6, 7, 8};
    drive_matrix(1'b0);
    drive_matrix(1'b1);
    @(posedge clk);
    while (seen < 2 && c < 40) begin
      @(negedge clk);
      in_valid = 1'b0; col_end = 1'b0; row_end = 1'b0;
      c++;
      if (valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL rst_mid_wait: saw %0d results within %0d cycles, required 2", seen, c);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || is_legal !== 1'b0 || out_data !== '0 ||
        change_row !== 1'b0 || dbg_state !== ST_LOAD_A) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%0b valid=%0b is_legal=%0b out_data=%0d change_row=%0b state=%0d, required all 0",
               busy, valid, is_legal, out_data, change_row, dbg_state);
    end
    for (int q = 0; q < 10; q++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet: valid=%0b required 0", valid);
      end
    end
    set_shape(1, 1, 1, 1);
    a_vals = '{3};
    b_vals = '{4};
    exp_q  = '{20'd12};
    run_job("after_rst_1x1", 1'b1, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_2x2();
    test_illegal_dims();
    test_1x1_ff();
    test_4x4_ff();
    test_shape_errors();
    test_random();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
